// File: rtl/la_debug_pkg.sv
// Shared types for the logic-analyzer debug controller: command opcodes and FSM states.
package la_debug_pkg;

  localparam int unsigned OpW = 3;

  typedef enum logic [OpW-1:0] {
    OpNop    = 3'd0,
    OpRead   = 3'd1,
    OpWrite  = 3'd2,
    OpHalt   = 3'd3,
    OpResume = 3'd4,
    OpStep   = 3'd5
  } la_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StStep,
    StResp
  } la_state_e;

endpackage

// File: rtl/la_tgl_sync.sv
// Two-flop synchroniser for a level-toggle strobe, with a one-cycle pulse per level change.
module la_tgl_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tgl_i,
  output logic edge_o
);

  // [0] and [1] are the metastability chain, [2] holds the previous synchronised level.
  logic [2:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], tgl_i};
    end
  end

  assign edge_o = sync_q[1] ^ sync_q[2];

endmodule

// File: rtl/la_debug_ctrl.sv
// Debug controller: turns toggle-handshaked LA probe commands into halt/resume/step control
// of the core clock enable and timed req/ack accesses to debug targets.
module la_debug_ctrl
  import la_debug_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned NUM_TARGETS  = 4,
  parameter int unsigned TGT_W        = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1,
  parameter int unsigned STEP_W       = 16,
  parameter int unsigned TIMEOUT      = 64,
  parameter bit          RUN_AT_RESET = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              la_cmd_tgl_i,
  input  logic [OpW-1:0]    la_cmd_op_i,
  input  logic [TGT_W-1:0]  la_cmd_tgt_i,
  input  logic [ADDR_W-1:0] la_cmd_addr_i,
  input  logic [DATA_W-1:0] la_cmd_wdata_i,
  output logic              la_rsp_tgl_o,
  output logic [DATA_W-1:0] la_rsp_rdata_o,
  output logic              la_rsp_err_o,
  output logic              la_overrun_o,
  output logic              core_run_en_o,
  output logic              core_halted_o,
  output logic              tgt_req_o,
  output logic              tgt_we_o,
  output logic [TGT_W-1:0]  tgt_sel_o,
  output logic [ADDR_W-1:0] tgt_addr_o,
  output logic [DATA_W-1:0] tgt_wdata_o,
  input  logic              tgt_ack_i,
  input  logic [DATA_W-1:0] tgt_rdata_i
);

  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  la_state_e state_q, state_d;
  logic              cmd_edge;
  logic              pend_q, pend_d, ovr_q, ovr_d;
  logic [OpW-1:0]    pnd_op_q, cur_op_q, sel_op;
  logic [TGT_W-1:0]  pnd_tgt_q, cur_tgt_q, sel_tgt;
  logic [ADDR_W-1:0] pnd_addr_q, cur_addr_q, sel_addr;
  logic [DATA_W-1:0] pnd_wdata_q, cur_wdata_q, sel_wdata;
  logic [STEP_W-1:0] step_q, step_d, sel_cnt;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              run_q, run_d, err_q, err_d, tgl_q, tgl_d, rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              pnd_load, cur_load, tgt_ok;

  la_tgl_sync u_cmd_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tgl_i  (la_cmd_tgl_i),
    .edge_o (cmd_edge)
  );

  // A pending command always wins over a fresh edge when the FSM is idle.
  assign sel_op    = pend_q ? pnd_op_q    : la_cmd_op_i;
  assign sel_tgt   = pend_q ? pnd_tgt_q   : la_cmd_tgt_i;
  assign sel_addr  = pend_q ? pnd_addr_q  : la_cmd_addr_i;
  assign sel_wdata = pend_q ? pnd_wdata_q : la_cmd_wdata_i;
  assign sel_cnt   = sel_wdata[STEP_W-1:0];
  assign tgt_ok    = 32'(sel_tgt) < NUM_TARGETS;

  always_comb begin
    pend_d   = pend_q;
    ovr_d    = ovr_q;
    pnd_load = 1'b0;
    if (cmd_edge) begin
      if (pend_q) begin
        ovr_d = 1'b1;
      end else if (state_q != StIdle) begin
        pend_d   = 1'b1;
        pnd_load = 1'b1;
      end
    end
    if (state_q == StIdle && pend_q) pend_d = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    err_d     = err_q;
    step_d    = step_q;
    tmo_d     = tmo_q;
    rdata_d   = rdata_q;
    tgl_d     = tgl_q;
    rsp_err_d = rsp_err_q;
    cur_load  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_edge || pend_q) begin
          cur_load = 1'b1;
          err_d    = 1'b0;
          state_d  = StResp;
          case (sel_op)
            OpNop:    ;
            OpHalt:   run_d = 1'b0;
            OpResume: run_d = 1'b1;
            OpRead, OpWrite: begin
              if (run_q || !tgt_ok) begin
                err_d = 1'b1;
              end else begin
                tmo_d   = '0;
                state_d = StAccess;
              end
            end
            OpStep: begin
              if (run_q) begin
                err_d = 1'b1;
              end else if (sel_cnt != '0) begin
                step_d  = sel_cnt;
                run_d   = 1'b1;
                state_d = StStep;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      StAccess: begin
        if (tgt_ack_i) begin
          if (cur_op_q == OpRead) rdata_d = tgt_rdata_i;
          state_d = StResp;
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StStep: begin
        if (step_q == STEP_W'(1)) begin
          run_d   = 1'b0;
          state_d = StResp;
        end else begin
          step_d = step_q - STEP_W'(1);
        end
      end
      StResp: begin
        tgl_d     = ~tgl_q;
        rsp_err_d = err_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      pend_q      <= 1'b0;
      ovr_q       <= 1'b0;
      pnd_op_q    <= '0;
      pnd_tgt_q   <= '0;
      pnd_addr_q  <= '0;
      pnd_wdata_q <= '0;
      cur_op_q    <= '0;
      cur_tgt_q   <= '0;
      cur_addr_q  <= '0;
      cur_wdata_q <= '0;
      step_q      <= '0;
      tmo_q       <= '0;
      run_q       <= RUN_AT_RESET;
      err_q       <= 1'b0;
      tgl_q       <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      step_q    <= step_d;
      tmo_q     <= tmo_d;
      run_q     <= run_d;
      err_q     <= err_d;
      tgl_q     <= tgl_d;
      rsp_err_q <= rsp_err_d;
      rdata_q   <= rdata_d;
      if (pnd_load) begin
        pnd_op_q    <= la_cmd_op_i;
        pnd_tgt_q   <= la_cmd_tgt_i;
        pnd_addr_q  <= la_cmd_addr_i;
        pnd_wdata_q <= la_cmd_wdata_i;
      end
      if (cur_load) begin
        cur_op_q    <= sel_op;
        cur_tgt_q   <= sel_tgt;
        cur_addr_q  <= sel_addr;
        cur_wdata_q <= sel_wdata;
      end
    end
  end

  assign la_rsp_tgl_o   = tgl_q;
  assign la_rsp_rdata_o = rdata_q;
  assign la_rsp_err_o   = rsp_err_q;
  assign la_overrun_o   = ovr_q;
  assign core_run_en_o  = run_q;
  assign core_halted_o  = ~run_q;
  assign tgt_req_o      = (state_q == StAccess);
  assign tgt_we_o       = tgt_req_o && (cur_op_q == OpWrite);
  assign tgt_sel_o      = cur_tgt_q;
  assign tgt_addr_o     = cur_addr_q;
  assign tgt_wdata_o    = cur_wdata_q;

endmodule

// File: tb/tb_la_debug_ctrl.sv
// Bench for la_debug_ctrl: directed scenarios plus random commands against a command-level model.
module tb_la_debug_ctrl;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NT = 4;
  localparam int TW = 3;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_tgl = 1'b0;
  logic [2:0]    cmd_op = '0;
  logic [TW-1:0] cmd_tgt = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_tgl, rsp_err, overrun, run_en, halted, tgt_req, tgt_we;
  logic [DW-1:0] rsp_rdata, tgt_wdata;
  logic [TW-1:0] tgt_sel;
  logic [AW-1:0] tgt_addr;
  logic          tgt_ack = 1'b0;
  logic [DW-1:0] tgt_rdata = '0;

  la_debug_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_TARGETS(NT), .TGT_W(TW), .STEP_W(16), .TIMEOUT(TMO),
    .RUN_AT_RESET(1'b0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .la_cmd_tgl_i(cmd_tgl), .la_cmd_op_i(cmd_op),
    .la_cmd_tgt_i(cmd_tgt), .la_cmd_addr_i(cmd_addr), .la_cmd_wdata_i(cmd_wdata),
    .la_rsp_tgl_o(rsp_tgl), .la_rsp_rdata_o(rsp_rdata), .la_rsp_err_o(rsp_err),
    .la_overrun_o(overrun), .core_run_en_o(run_en), .core_halted_o(halted),
    .tgt_req_o(tgt_req), .tgt_we_o(tgt_we), .tgt_sel_o(tgt_sel), .tgt_addr_o(tgt_addr),
    .tgt_wdata_o(tgt_wdata), .tgt_ack_i(tgt_ack), .tgt_rdata_i(tgt_rdata)
  );

  int compared = 0;
  int mismatched = 0;

  // Activity counters, sampled on the falling edge.
  int   rsp_cnt = 0, req_cyc = 0, we_cyc = 0, run_cyc = 0;
  logic last_tgl = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      last_tgl <= 1'b0;
    end else begin
      if (rsp_tgl !== last_tgl) rsp_cnt <= rsp_cnt + 1;
      last_tgl <= rsp_tgl;
      if (tgt_req) req_cyc <= req_cyc + 1;
      if (tgt_req && tgt_we) we_cyc <= we_cyc + 1;
      if (run_en) run_cyc <= run_cyc + 1;
    end
  end

  function automatic logic [31:0] dflt(input int key);
    return 32'hA500_0000 + 32'(key);
  endfunction

  // Target memory: acks on the ack_delay-th request cycle; 0 means never.
  int          ack_delay = 1;
  int          acnt = 0;
  logic [31:0] tgt_mem [int];
  always @(negedge clk) begin
    if (rst) begin
      tgt_ack <= 1'b0;
      acnt    <= 0;
    end else if (tgt_req && !tgt_ack) begin
      acnt <= acnt + 1;
      if (ack_delay != 0 && acnt + 1 == ack_delay) begin
        int k;
        k = int'(tgt_sel) * 256 + int'(tgt_addr);
        tgt_ack <= 1'b1;
        if (tgt_we) tgt_mem[k] = tgt_wdata;
        tgt_rdata <= tgt_mem.exists(k) ? tgt_mem[k] : dflt(k);
      end else begin
        tgt_rdata <= $urandom;
      end
    end else begin
      tgt_ack   <= 1'b0;
      acnt      <= 0;
      tgt_rdata <= $urandom;
    end
  end

  // Reference model state
  bit          halted_m = 1'b1;
  bit          ovr_m = 1'b0;
  logic [31:0] rdata_m = '0;
  logic [31:0] mem_m [int];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] tgt, input logic [7:0] addr,
                       input logic [31:0] wd);
    @(negedge clk);
    cmd_op = op; cmd_tgt = tgt; cmd_addr = addr; cmd_wdata = wd;
    repeat (2) @(negedge clk);
    cmd_tgl = ~cmd_tgl;
  endtask

  task automatic wait_rsp(input int start, output bit ok);
    int n;
    n = 0;
    while (rsp_cnt == start && n < 400) begin
      @(negedge clk);
      n++;
    end
    ok = (rsp_cnt != start);
    @(negedge clk);
  endtask

  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [2:0] tgt,
                        input logic [7:0] addr, input logic [31:0] wd, input int delay);
    int key, exp_req, exp_run, r0, q0, w0, u0;
    bit exp_err, ok, was_halted;
    key = int'(tgt) * 256 + int'(addr);
    exp_err = 1'b0; exp_req = 0; exp_run = 0; was_halted = halted_m;
    case (op)
      3'd0: ;
      3'd3: halted_m = 1'b1;
      3'd4: halted_m = 1'b0;
      3'd1, 3'd2: begin
        if (!halted_m || int'(tgt) >= NT) begin
          exp_err = 1'b1;
        end else if (delay == 0 || delay > TMO) begin
          exp_err = 1'b1;
          exp_req = TMO;
        end else begin
          exp_req = delay;
          if (op == 3'd2) mem_m[key] = wd;
          else rdata_m = mem_m.exists(key) ? mem_m[key] : dflt(key);
        end
      end
      3'd5: begin
        if (!halted_m) exp_err = 1'b1;
        else exp_run = int'(wd[15:0]);
      end
      default: exp_err = 1'b1;
    endcase
    ack_delay = delay;
    r0 = rsp_cnt; q0 = req_cyc; w0 = we_cyc; u0 = run_cyc;
    issue(op, tgt, addr, wd);
    wait_rsp(r0, ok);
    check({tag, ".done"}, 64'(ok), 64'(1));
    check({tag, ".nrsp"}, 64'(rsp_cnt - r0), 64'(1));
    check({tag, ".err"}, 64'(rsp_err), 64'(exp_err));
    check({tag, ".rdata"}, 64'(rsp_rdata), 64'(rdata_m));
    check({tag, ".req_cyc"}, 64'(req_cyc - q0), 64'(exp_req));
    check({tag, ".we_cyc"}, 64'(we_cyc - w0), 64'(op == 3'd2 ? exp_req : 0));
    check({tag, ".run_en"}, 64'(run_en), 64'(!halted_m));
    check({tag, ".halted"}, 64'(halted), 64'(halted_m));
    check({tag, ".overrun"}, 64'(overrun), 64'(ovr_m));
    if (was_halted && halted_m) check({tag, ".run_cyc"}, 64'(run_cyc - u0), 64'(exp_run));
  endtask

  initial begin
    int r0, q0, w0, n;
    bit ok;
    logic [2:0]  op, tgt;
    logic [31:0] wd;
    int          dly, bucket;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset.run_en", 64'(run_en), 64'(0));
    check("reset.halted", 64'(halted), 64'(1));
    check("reset.rsp_tgl", 64'(rsp_tgl), 64'(0));
    check("reset.rsp_err", 64'(rsp_err), 64'(0));
    check("reset.rdata", 64'(rsp_rdata), 64'(0));
    check("reset.overrun", 64'(overrun), 64'(0));
    check("reset.req", 64'({tgt_req, tgt_we}), 64'(0));

    do_cmd("halt0", 3'd3, 3'd0, 8'h00, 32'h0, 1);
    do_cmd("write1", 3'd2, 3'd1, 8'h05, 32'hDEAD_BEEF, 3);
    do_cmd("read1", 3'd1, 3'd1, 8'h05, 32'h0, 3);
    do_cmd("step5", 3'd5, 3'd0, 8'h00, 32'h0000_0005, 1);
    do_cmd("step0", 3'd5, 3'd0, 8'h00, 32'hFFFF_0000, 1);
    do_cmd("resume", 3'd4, 3'd0, 8'h00, 32'h0, 1);
    do_cmd("read_run", 3'd1, 3'd0, 8'h01, 32'h0, 1);
    do_cmd("step_run", 3'd5, 3'd0, 8'h00, 32'h3, 1);
    do_cmd("halt1", 3'd3, 3'd0, 8'h00, 32'h0, 1);
    do_cmd("read_tgt5", 3'd1, 3'd5, 8'h05, 32'h0, 1);
    do_cmd("op7", 3'd7, 3'd0, 8'h00, 32'h0, 1);
    do_cmd("op6", 3'd6, 3'd1, 8'h00, 32'h0, 1);
    do_cmd("tmo_noack", 3'd1, 3'd2, 8'h07, 32'h0, 0);
    do_cmd("tmo_ack63", 3'd1, 3'd3, 8'h07, 32'h0, 64);
    do_cmd("tmo_late", 3'd2, 3'd3, 8'h07, 32'h1234_5678, 65);

    // Three toggles inside one 20-cycle access: second queued, third lost.
    ack_delay = 20;
    r0 = rsp_cnt; q0 = req_cyc; w0 = we_cyc;
    issue(3'd2, 3'd2, 8'h09, 32'hCAFE_F00D);
    repeat (4) @(negedge clk);
    cmd_op = 3'd1;
    repeat (2) @(negedge clk);
    cmd_tgl = ~cmd_tgl;
    repeat (4) @(negedge clk);
    cmd_op = 3'd3;
    repeat (2) @(negedge clk);
    cmd_tgl = ~cmd_tgl;
    repeat (100) @(negedge clk);
    mem_m[2 * 256 + 9] = 32'hCAFE_F00D;
    rdata_m = 32'hCAFE_F00D;
    ovr_m = 1'b1;
    check("ovr.nrsp", 64'(rsp_cnt - r0), 64'(2));
    check("ovr.err", 64'(rsp_err), 64'(0));
    check("ovr.rdata", 64'(rsp_rdata), 64'(rdata_m));
    check("ovr.overrun", 64'(overrun), 64'(1));
    check("ovr.req_cyc", 64'(req_cyc - q0), 64'(40));
    check("ovr.we_cyc", 64'(we_cyc - w0), 64'(20));

    // Reset in the middle of an access that never completes.
    ack_delay = 0;
    r0 = rsp_cnt;
    issue(3'd1, 3'd0, 8'h01, 32'h0);
    n = 0;
    while (!tgt_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst.req_seen", 64'(tgt_req), 64'(1));
    #2;
    rst = 1'b1;
    cmd_tgl = 1'b0;
    #1;
    check("rst.req_async", 64'(tgt_req), 64'(0));
    check("rst.rsp_tgl", 64'(rsp_tgl), 64'(0));
    check("rst.run_en", 64'(run_en), 64'(0));
    check("rst.overrun", 64'(overrun), 64'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    halted_m = 1'b1; ovr_m = 1'b0; rdata_m = '0;
    repeat (10) @(negedge clk);
    check("rst.no_rsp", 64'(rsp_cnt - r0), 64'(0));
    check("rst.idle_req", 64'(tgt_req), 64'(0));
    do_cmd("rst.halt", 3'd3, 3'd0, 8'h00, 32'h0, 1);

    for (int i = 0; i < 40; i++) begin
      bucket = $urandom_range(0, 9);
      if (bucket <= 3) op = 3'd1;
      else if (bucket <= 6) op = 3'd2;
      else if (bucket == 7) op = 3'd5;
      else if (bucket == 8) op = 3'($urandom_range(3, 4));
      else op = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(6, 7));
      tgt = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      wd = $urandom;
      if (op == 3'd5) wd[15:0] = 16'($urandom_range(0, 6));
      dly = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 8);
      do_cmd($sformatf("rnd%0d", i), op, tgt, 8'($urandom_range(0, 7)), wd, dly);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
